// File: rtl/mod_calc_pkg.sv
// Shared types and helpers for the iterative residue engine.
package mod_calc_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Widest operand the reference function accepts.
  localparam int unsigned RefW = 512;

  // Number of K-bit chunks needed to cover an XW-bit operand.
  function automatic int unsigned clog2_ceil_div(int unsigned xw, int unsigned k);
    return (xw + k - 1) / k;
  endfunction

  function automatic int unsigned mod_ref(bit [RefW-1:0] x, int unsigned m);
    longint unsigned acc;
    acc = 64'd0;
    for (int i = RefW - 1; i >= 0; i--) begin
      acc = ((acc << 1) | {63'd0, x[i]}) % {32'd0, m};
    end
    return acc[31:0];
  endfunction

endpackage

// File: rtl/seq_x_mod_m_if.sv
// Operand/residue handshake bundle between source, engine and consumer.
interface seq_x_mod_m_if #(
  parameter int unsigned XW = 500,
  parameter int unsigned MW = 9
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] r;
  logic          busy;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, r, busy
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, r, busy
  );
endinterface

// File: rtl/mod_step_m.sv
// One Horner step: (r * 2^K + c) mod M via K+1 restoring compare/subtract stages.
module mod_step_m #(
  parameter int unsigned M  = 461,
  parameter int unsigned K  = 9,
  localparam int unsigned MW = $clog2(M)
) (
  input  logic [MW-1:0] r_i,
  input  logic [K-1:0]  c_i,
  output logic [MW-1:0] res_o
);

  localparam int unsigned TW = MW + K;

  // One spare bit so M*2^K itself is representable when M is a power of two.
  typedef logic [TW:0] wide_t;

  function automatic logic [MW-1:0] reduce(logic [MW-1:0] r, logic [K-1:0] c);
    wide_t t;
    t = {1'b0, r, c};
    for (int j = int'(K); j >= 0; j--) begin
      if (t >= (wide_t'(M) << j)) begin
        t = t - (wide_t'(M) << j);
      end
    end
    return t[MW-1:0];
  endfunction

  always_comb begin
    res_o = reduce(r_i, c_i);
  end

endmodule

// File: rtl/seq_x_mod_m.sv
// Iterative residue engine: R = X mod M, consuming X MSB-first in K-bit chunks.
module seq_x_mod_m
  import mod_calc_pkg::*;
#(
  parameter int unsigned XW = 500,
  parameter int unsigned M  = 461,
  parameter int unsigned K  = 9
) (
  input logic          clk,
  input logic          rst_n,
  seq_x_mod_m_if.slave bus
);

  localparam int unsigned MW = $clog2(M);
  localparam int unsigned NC = clog2_ceil_div(XW, K);
  localparam int unsigned SW = NC * K;
  localparam int unsigned CW = (NC > 1) ? $clog2(NC) : 1;

  if (XW < 1 || K < 1 || M < 2) begin : g_param_check
    $error("seq_x_mod_m: illegal parameters XW=%0d M=%0d K=%0d", XW, M, K);
  end

  state_e          state_q, state_d;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [MW-1:0]   r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [K-1:0]    chunk;
  logic [MW-1:0]   step_res;

  assign chunk = shreg_q[SW-1 -: K];

  mod_step_m #(
    .M (M),
    .K (K)
  ) u_step (
    .r_i   (r_q),
    .c_i   (chunk),
    .res_o (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)  state_d = StRun;
      StRun:   if (cnt_q == '0)   state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.r         = r_q;
  end

  always_comb begin
    shreg_d = shreg_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d = SW'(bus.x);
          r_d     = '0;
          cnt_d   = CW'(NC - 1);
        end
      end
      StRun: begin
        r_d     = step_res;
        shreg_d = shreg_q << K;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
